// File: rtl/fsm_output_tracer.sv
// fsm_output_tracer
// Capture stage that watches a controller FSM output vector and records every
// distinct value, tagged with a free-running cycle timestamp, into a small
// first-word-fall-through FIFO that a harness drains over valid/ready.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rst         synchronous active-high reset
//   y_in        monitored FSM output vector (DATA_W bits)
//   trace_en    capture enable
//   out_valid   FIFO head entry available
//   out_ready   consumer accepts the head entry
//   out_data    head entry {timestamp, y value}, timestamp in the MSBs
//   out_count   current FIFO occupancy
//   overflow    sticky flag, at least one entry was dropped
//   drop_count  saturating count of dropped entries

module fsm_output_tracer #(
    parameter int DATA_W = 17,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          y_in,
    input  logic                       trace_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W+DATA_W-1:0]     out_data,
    output logic [$clog2(DEPTH):0]     out_count,
    output logic                       overflow,
    output logic [DROP_W-1:0]          drop_count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = TS_W + DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_phase;
    state_t               w_nextState;
    logic                 w_log;
    logic                 w_updPrev;

    logic [TS_W-1:0]      r_ts;
    logic [DATA_W-1:0]    r_yPrev;
    logic [ENTRY_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wrPtr;
    logic [PTR_W-1:0]     r_rdPtr;
    logic [CNT_W-1:0]     r_count;
    logic [ENTRY_W-1:0]   r_outData;
    logic                 r_overflow;
    logic [DROP_W-1:0]    r_dropCount;

    logic                 w_pop;
    logic                 w_full;
    logic                 w_push;
    logic                 w_drop;
    logic [ENTRY_W-1:0]   w_wrData;
    logic [PTR_W-1:0]     w_rdPtrNext;
    logic [CNT_W-1:0]     w_countNext;
    logic                 w_headFromWrite;

    // The register only ever holds IDLE or TRACK. The arming cycle is the
    // first enabled cycle seen from IDLE, so the baseline is logged with the
    // timestamp of the very cycle trace_en is first high rather than one
    // cycle later. That cycle is presented here as the ARM phase.
    always_comb begin
        w_phase     = r_state;
        w_nextState = r_state;
        w_log       = 1'b0;
        w_updPrev   = 1'b0;
        if ((r_state == IDLE) && trace_en) begin
            w_phase = ARM;
        end
        case (w_phase)
            IDLE: begin
                w_nextState = IDLE;
            end
            ARM: begin
                w_log       = 1'b1;
                w_updPrev   = 1'b1;
                w_nextState = TRACK;
            end
            TRACK: begin
                if (!trace_en) begin
                    w_nextState = IDLE;
                end else begin
                    w_updPrev = 1'b1;
                    w_log     = (y_in != r_yPrev);
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // FIFO control. A pop in the same cycle frees a slot for a push into a
    // full FIFO. The head register is reloaded from the incoming entry when
    // that entry lands in an otherwise empty FIFO, and from storage otherwise.
    always_comb begin
        w_pop           = (r_count != '0) && out_ready;
        w_full          = (r_count == CNT_W'(DEPTH));
        w_push          = w_log && (!w_full || w_pop);
        w_drop          = w_log && w_full && !w_pop;
        w_wrData        = {r_ts, y_in};
        w_rdPtrNext     = r_rdPtr + PTR_W'(w_pop);
        w_countNext     = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        w_headFromWrite = w_push && (r_count == CNT_W'(w_pop));
    end

    // Entry storage, left unreset since occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wrPtr] <= w_wrData;
        end
    end

    // State, timestamp, pointers, head register and drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ts        <= '0;
            r_yPrev     <= '0;
            r_wrPtr     <= '0;
            r_rdPtr     <= '0;
            r_count     <= '0;
            r_outData   <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_ts    <= r_ts + TS_W'(1);
            if (w_updPrev) begin
                r_yPrev <= y_in;
            end
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr <= w_rdPtrNext;
            r_count <= w_countNext;
            if (w_countNext != '0) begin
                r_outData <= w_headFromWrite ? w_wrData : r_mem[w_rdPtrNext];
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_dropCount != '1) begin
                    r_dropCount <= r_dropCount + DROP_W'(1);
                end
            end
        end
    end

    // Output mapping; every output comes straight from a register.
    always_comb begin
        out_valid  = (r_count != '0);
        out_data   = r_outData;
        out_count  = r_count;
        overflow   = r_overflow;
        drop_count = r_dropCount;
    end

endmodule

// File: tb/tb_fsm_output_tracer.sv
// tb_fsm_output_tracer
// Directed bench for fsm_output_tracer: reset state, baseline capture, change
// detection, overflow, full-with-pop, enable gating and reset during a drain.
// Expected entries are worked out by hand from the cycle timestamps.

module tb_fsm_output_tracer;

    localparam logic [16:0] YA = 17'h0AAAA;
    localparam logic [16:0] YB = 17'h15555;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [16:0] y_in = '0;
    logic        trace_en = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [32:0] out_data;
    logic [4:0]  out_count;
    logic        overflow;
    logic [7:0]  drop_count;

    int vectors = 0;
    int miscompares = 0;

    fsm_output_tracer #(
        .DATA_W (17),
        .TS_W   (16),
        .DEPTH  (16),
        .DROP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .y_in       (y_in),
        .trace_en   (trace_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_count  (out_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then land 1 unit after the closing edge so
    // outputs are sampled well away from it.
    task automatic applyStimulus(input logic en, input logic [16:0] y, input logic rdy);
        trace_en  = en;
        y_in      = y;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic [32:0] entry(input logic [15:0] ts, input logic [16:0] y);
        return {ts, y};
    endfunction

    function automatic logic [16:0] toggleY(input int i);
        return i[0] ? YB : YA;
    endfunction

    // Linear sequence of directed steps.
    initial begin
        $display("[TB] reset and baseline");
        rst = 1'b1;
        applyStimulus(0, 17'h0, 0);
        applyStimulus(0, 17'h0, 0);
        rst = 1'b0;
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_count", out_count, 0);
        checkOutput("rst_data", out_data, 0);
        checkOutput("rst_ovf", overflow, 0);
        checkOutput("rst_drop", drop_count, 0);
        applyStimulus(1, 17'h0, 0);
        checkOutput("base_latency", out_count, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1, 17'h0, 0);
        checkOutput("base_count", out_count, 1);
        checkOutput("base_valid", out_valid, 1);
        checkOutput("base_data", out_data, entry(16'd0, 17'h0));
        checkOutput("base_ovf", overflow, 0);

        $display("[TB] change detection");
        rst = 1'b1;
        applyStimulus(0, 17'h0, 0);
        rst = 1'b0;
        applyStimulus(1, 17'h0, 1);
        checkOutput("chg_e0_valid", out_valid, 1);
        checkOutput("chg_e0_data", out_data, entry(16'd0, 17'h0));
        checkOutput("chg_e0_count", out_count, 1);
        applyStimulus(1, 17'h0, 1);
        checkOutput("chg_ts1_empty", out_valid, 0);
        applyStimulus(1, 17'h0, 1);
        checkOutput("chg_ts2_empty", out_valid, 0);
        checkOutput("chg_ts2_count", out_count, 0);
        applyStimulus(1, 17'h04141, 1);
        checkOutput("chg_e1_valid", out_valid, 1);
        checkOutput("chg_e1_data", out_data, entry(16'd3, 17'h04141));
        applyStimulus(1, 17'h04141, 1);
        checkOutput("chg_same_empty", out_valid, 0);
        applyStimulus(1, 17'h04141, 1);
        checkOutput("chg_ts5_empty", out_valid, 0);
        applyStimulus(1, 17'h00181, 1);
        checkOutput("chg_e2_valid", out_valid, 1);
        checkOutput("chg_e2_data", out_data, entry(16'd6, 17'h00181));
        applyStimulus(1, 17'h00181, 1);
        checkOutput("chg_end_empty", out_valid, 0);
        checkOutput("chg_end_count", out_count, 0);

        $display("[TB] overflow");
        rst = 1'b1;
        applyStimulus(0, 17'h0, 0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) applyStimulus(1, toggleY(i), 0);
        checkOutput("ovf_count", out_count, 16);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_drops", drop_count, 4);
        for (int i = 0; i < 16; i++) begin
            checkOutput("ovf_head_valid", out_valid, 1);
            checkOutput("ovf_head_data", out_data, entry(i[15:0], toggleY(i)));
            applyStimulus(0, YA, 1);
        end
        checkOutput("ovf_drained_valid", out_valid, 0);
        checkOutput("ovf_drained_count", out_count, 0);
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_drops_kept", drop_count, 4);

        $display("[TB] full with simultaneous pop");
        rst = 1'b1;
        applyStimulus(0, 17'h0, 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) applyStimulus(1, toggleY(i), 0);
        checkOutput("full_count", out_count, 16);
        checkOutput("full_drops", drop_count, 0);
        for (int i = 16; i < 20; i++) begin
            applyStimulus(1, toggleY(i), 1);
            checkOutput("fullpop_count", out_count, 16);
            checkOutput("fullpop_drops", drop_count, 0);
            checkOutput("fullpop_ovf", overflow, 0);
        end
        checkOutput("fullpop_head", out_data, entry(16'd4, YA));
        applyStimulus(1, toggleY(20), 0);
        checkOutput("fulldrop_drops", drop_count, 1);
        checkOutput("fulldrop_ovf", overflow, 1);
        checkOutput("fulldrop_count", out_count, 16);

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 11; i++) applyStimulus(0, YA, 1);
        checkOutput("drain_count", out_count, 5);
        checkOutput("drain_head", out_data, entry(16'd15, YB));
        rst = 1'b1;
        applyStimulus(0, YA, 1);
        rst = 1'b0;
        checkOutput("rstmid_valid", out_valid, 0);
        checkOutput("rstmid_count", out_count, 0);
        checkOutput("rstmid_ovf", overflow, 0);
        checkOutput("rstmid_drops", drop_count, 0);
        applyStimulus(1, 17'h00123, 0);
        checkOutput("rstmid_ts_count", out_count, 1);
        checkOutput("rstmid_ts_data", out_data, entry(16'd0, 17'h00123));

        $display("[TB] enable gating");
        rst = 1'b1;
        applyStimulus(0, 17'h0, 0);
        rst = 1'b0;
        applyStimulus(1, 17'h00011, 0);
        applyStimulus(1, 17'h00011, 0);
        checkOutput("gate_pre_count", out_count, 1);
        applyStimulus(0, 17'h00022, 0);
        applyStimulus(0, 17'h00033, 0);
        applyStimulus(0, 17'h00044, 0);
        checkOutput("gate_off_count", out_count, 1);
        applyStimulus(1, 17'h00011, 0);
        checkOutput("gate_rearm_count", out_count, 2);
        checkOutput("gate_head0", out_data, entry(16'd0, 17'h00011));
        applyStimulus(0, 17'h00011, 1);
        checkOutput("gate_head1", out_data, entry(16'd5, 17'h00011));
        checkOutput("gate_final_count", out_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fsm_output_tracer.md
Name: fsm_output_tracer

Overview:
- Downstream capture stage for the benchmark controller FSMs; sits directly on their y output vector.
- Samples the output vector every cycle and logs each distinct value with a cycle timestamp into a FIFO.
- The FIFO is drained by the test/analysis harness over a valid/ready interface.
- Purpose: build output-sequence traces for golden-vs-suspect comparison. Rare-trigger sequence deviations show up as differing logged entries.

Parameters:
- DATA_W, 17, width of monitored output vector.
- TS_W, 16, timestamp counter width.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DROP_W, 8, drop counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- y_in  in  DATA_W  monitored FSM output vector.
- trace_en  in  1  capture enable.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_data  out  TS_W+DATA_W  {timestamp, y value}; timestamp in the MSBs.
- out_count  out  log2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky flag; at least one entry dropped.
- drop_count  out  DROP_W  saturating count of dropped entries.

Behaviour:
- Reset (rst=1 at a rising edge):
  - FIFO emptied; out_valid=0, out_count=0.
  - out_data=0, overflow=0, drop_count=0.
  - Timestamp counter ts=0; y_prev=0; state=IDLE.
  - Reset mid-operation discards all entries, including an entry that is being handshaken in the same cycle.
- Timestamp: ts increments by 1 every non-reset cycle, regardless of trace_en. It wraps from 2^TS_W-1 to 0.
- State machine:
  - IDLE: no capture. If trace_en=1, go to ARM. y_prev is not updated.
  - ARM: entered when trace_en rises. The first enabled cycle logs {ts, y_in} unconditionally as a baseline; y_prev<=y_in; go to TRACK. If trace_en=0, go to IDLE and log nothing.
  - TRACK: if y_in != y_prev, log {ts, y_in}. y_prev<=y_in every cycle. If trace_en=0, go to IDLE and log nothing that cycle.
  - Re-enabling after IDLE always passes through ARM again, so a new baseline is logged.
- Push: a log event at cycle N writes the FIFO at the edge ending N. out_valid is high from cycle N+1 when the FIFO was empty (latency 1). There is no combinational path from y_in to outputs.
- FIFO behaviour:
  - First-word-fall-through: out_data shows the head entry whenever out_valid=1.
  - out_data holds its last value when empty; verification must not check it while out_valid=0.
  - Pop occurs when out_valid and out_ready are both 1 at a rising edge.
  - Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Boundary conditions:
  - Full, push, no pop: entry dropped; overflow<=1 (sticky until rst); drop_count+=1, saturating at 2^DROP_W-1.
  - Full, push and pop in the same cycle: pop frees a slot, push accepted, no drop, count unchanged.
  - Empty, push and pop in the same cycle: pop ignored because out_valid=0; push accepted; count becomes 1.
  - out_ready while empty: no effect.
- Ordering: entries are strictly FIFO. Timestamps are monotonic modulo 2^TS_W.
- X handling: y_in is compared bitwise as given. The bench drives known values only.

Test Plan:
- Baseline after reset: rst for 2 cycles, then trace_en=1 with y_in=17'h00000 constant for 5 cycles, out_ready=0 -> exactly one entry {ts=0x0000, y=0x00000}, out_count=1, overflow=0.
- Change detection: with trace_en=1 from ts=0, drive y_in=0x00000 (ts0), 0x04141 (ts3), 0x04141 (ts4), 0x00181 (ts6), out_ready=1 -> entries popped in order (0,0x00000), (3,0x04141), (6,0x00181), each visible one cycle after its ts.
- Overflow: DEPTH=16, out_ready=0, toggle y_in every cycle for 20 enabled cycles -> out_count=16, overflow=1, drop_count=4. Then drain 16 entries -> their timestamps are the first 16 logged cycles.
- Full with simultaneous pop: fill to 16, then hold out_ready=1 while toggling y_in -> no drops, out_count stays 16, drop_count unchanged.
- Enable gating: trace_en 1→0 for 3 cycles while y_in changes, then 0→1 -> no entries during the disabled cycles; one new baseline entry with the current y_in on the first re-enabled cycle.
- Reset mid-drain: 5 entries queued, assert rst on a cycle with out_valid=out_ready=1 -> next cycle out_valid=0, out_count=0, overflow=0, drop_count=0, ts restarts at 0.
